// File: rtl/mem_wb_pipe_pkg.sv
// Shared widths and constants for the MEM->WB writeback pipe.
// Defaults mirror the core-wide data, register-address and stall-bus sizes.
package mem_wb_pipe_pkg;

    localparam int DATA_SIZE         = 32;
    localparam int DATA_ADDRESS_SIZE = 5;
    localparam int STALL_SIZE        = 6;
    localparam int STALL_WB          = 4;
    localparam int RETIRE_CNT_W      = 32;
    localparam int MAX_DEPTH         = 4;

    // Register x0 is hardwired to zero, so a write to it is never valid.
    function automatic logic qualify_write(input logic flag, input logic [DATA_ADDRESS_SIZE-1:0] addr);
        return flag && (addr != '0);
    endfunction

endpackage

// File: rtl/mem_wb_pipe_if.sv
// Request, writeback and forwarding-lookup signals of the writeback pipe.
// The pipe itself uses the slave view; the MEM stage / register file side uses master.
interface mem_wb_pipe_if
    import mem_wb_pipe_pkg::*;
#(
    parameter int DATA_W = DATA_SIZE,
    parameter int ADDR_W = DATA_ADDRESS_SIZE
);
    logic              modify_flag;
    logic [ADDR_W-1:0] modify_address;
    logic [DATA_W-1:0] modify_data;

    logic              _modify_flag;
    logic [ADDR_W-1:0] _modify_address;
    logic [DATA_W-1:0] _modify_data;

    logic [ADDR_W-1:0] fwd_address;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    modport master (
        output modify_flag, modify_address, modify_data, fwd_address,
        input  _modify_flag, _modify_address, _modify_data, fwd_hit, fwd_data
    );

    modport slave (
        input  modify_flag, modify_address, modify_data, fwd_address,
        output _modify_flag, _modify_address, _modify_data, fwd_hit, fwd_data
    );
endinterface

// File: rtl/mem_wb_pipe_wb_stage_reg.sv
// One writeback pipeline stage: flag/address/data register.
// Flush clears the entry, hold keeps it, otherwise it loads the upstream value.
module wb_stage_reg #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              hold_i,
    input  logic              flag_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              flag_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o
);
    logic              flag_q, flag_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        flag_d = flag_q;
        addr_d = addr_q;
        data_d = data_q;
        if (flush_i) begin
            flag_d = 1'b0;
            addr_d = '0;
            data_d = '0;
        end else if (!hold_i) begin
            flag_d = flag_i;
            addr_d = addr_i;
            data_d = data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            flag_q <= flag_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign flag_o = flag_q;
    assign addr_o = addr_q;
    assign data_o = data_q;
endmodule

// File: rtl/mem_wb_pipe.sv
// DEPTH-stage MEM->WB writeback pipe with hold/flush, in-flight forwarding
// lookup and a count of writes delivered to the register file.
module mem_wb_pipe
    import mem_wb_pipe_pkg::*;
#(
    parameter int DATA_W    = DATA_SIZE,
    parameter int ADDR_W    = DATA_ADDRESS_SIZE,
    parameter int DEPTH     = 1,
    parameter int STALL_W   = STALL_SIZE,
    parameter int STALL_BIT = STALL_WB,
    parameter int CNT_W     = RETIRE_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall_state,
    input  logic               flush,
    mem_wb_pipe_if.slave       bus,
    output logic [CNT_W-1:0]   retire_count
);
    if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
        $error("mem_wb_pipe: DEPTH=%0d outside legal range 1..%0d", DEPTH, MAX_DEPTH);
    end

    logic hold;
    logic unused_stall;
    assign hold         = stall_state[STALL_BIT];
    assign unused_stall = ^stall_state;

    logic [DEPTH-1:0]             stg_flag, in_flag;
    logic [DEPTH-1:0][ADDR_W-1:0] stg_addr, in_addr;
    logic [DEPTH-1:0][DATA_W-1:0] stg_data, in_data;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            // x0 requests still occupy the slot but never become valid.
            assign in_flag[k] = qualify_write(bus.modify_flag, bus.modify_address);
            assign in_addr[k] = bus.modify_address;
            assign in_data[k] = bus.modify_data;
        end else begin : g_tail
            assign in_flag[k] = stg_flag[k-1];
            assign in_addr[k] = stg_addr[k-1];
            assign in_data[k] = stg_data[k-1];
        end

        wb_stage_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .flush_i (flush),
            .hold_i  (hold),
            .flag_i  (in_flag[k]),
            .addr_i  (in_addr[k]),
            .data_i  (in_data[k]),
            .flag_o  (stg_flag[k]),
            .addr_o  (stg_addr[k]),
            .data_o  (stg_data[k])
        );
    end

    // Gating by hold makes a held entry fire only in the cycle it actually leaves.
    logic wb_flag;
    assign wb_flag              = stg_flag[DEPTH-1] & ~hold & ~flush;
    assign bus._modify_flag     = wb_flag;
    assign bus._modify_address  = stg_addr[DEPTH-1];
    assign bus._modify_data     = stg_data[DEPTH-1];

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, wb_flag};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign retire_count = cnt_q;

    // Scan oldest to youngest so the youngest match overrides earlier ones.
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (stg_flag[k] && (stg_addr[k] == bus.fwd_address) && (bus.fwd_address != '0)) begin
                fwd_hit  = 1'b1;
                fwd_data = stg_data[k];
            end
        end
    end

    assign bus.fwd_hit  = fwd_hit;
    assign bus.fwd_data = fwd_data;
endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe at DEPTH=1 (CNT_W=4), DEPTH=2 and DEPTH=3.
module tb_mem_wb_pipe;
    localparam logic [5:0] HOLD = 6'b010000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst1, rst2, rst3;
    logic [5:0] st1, st2, st3;
    logic       fl1, fl2, fl3;
    logic [3:0]  cnt1;
    logic [31:0] cnt2, cnt3;

    int tests = 0;
    int fails = 0;

    mem_wb_pipe_if #(.DATA_W(32), .ADDR_W(5)) if1 ();
    mem_wb_pipe_if #(.DATA_W(32), .ADDR_W(5)) if2 ();
    mem_wb_pipe_if #(.DATA_W(32), .ADDR_W(5)) if3 ();

    mem_wb_pipe #(.DEPTH(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst1), .stall_state(st1), .flush(fl1), .bus(if1), .retire_count(cnt1));
    mem_wb_pipe #(.DEPTH(2)) dut2 (
        .clk(clk), .rst(rst2), .stall_state(st2), .flush(fl2), .bus(if2), .retire_count(cnt2));
    mem_wb_pipe #(.DEPTH(3)) dut3 (
        .clk(clk), .rst(rst3), .stall_state(st3), .flush(fl3), .bus(if3), .retire_count(cnt3));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst1 = 1; rst2 = 1; rst3 = 1;
        st1 = '0; st2 = '0; st3 = '0;
        fl1 = 0; fl2 = 0; fl3 = 0;
        if1.modify_flag = 0; if1.modify_address = '0; if1.modify_data = '0; if1.fwd_address = 5'd7;
        if2.modify_flag = 0; if2.modify_address = '0; if2.modify_data = '0; if2.fwd_address = 5'd5;
        if3.modify_flag = 0; if3.modify_address = '0; if3.modify_data = '0; if3.fwd_address = 5'd1;
        tick();
        check("rst_flag2", if2._modify_flag, 0);
        check("rst_addr2", if2._modify_address, 0);
        check("rst_data2", if2._modify_data, 0);
        check("rst_hit3", if3.fwd_hit, 0);
        check("rst_fdata3", if3.fwd_data, 0);
        check("rst_cnt1", cnt1, 0);
        tick();
        rst1 = 0; rst2 = 0; rst3 = 0;

        // DEPTH=2 latency: write enable only in cycle 2
        if2.modify_flag = 1; if2.modify_address = 5'd5; if2.modify_data = 32'hDEADBEEF;
        tick();
        if2.modify_flag = 0; if2.modify_address = '0; if2.modify_data = '0;
        #1;
        check("A_c1_flag", if2._modify_flag, 0);
        check("A_c1_hit", if2.fwd_hit, 1);
        check("A_c1_fdata", if2.fwd_data, 32'hDEADBEEF);
        tick();
        check("A_c2_flag", if2._modify_flag, 1);
        check("A_c2_addr", if2._modify_address, 5);
        check("A_c2_data", if2._modify_data, 32'hDEADBEEF);
        check("A_c2_cnt", cnt2, 0);
        tick();
        check("A_c3_flag", if2._modify_flag, 0);
        check("A_c3_cnt", cnt2, 1);

        // x0 request: captured data, never valid
        if2.modify_flag = 1; if2.modify_address = 5'd0; if2.modify_data = 32'hFFFFFFFF;
        tick();
        if2.modify_flag = 0; if2.modify_data = '0; if2.fwd_address = 5'd0;
        #1;
        check("E_hit", if2.fwd_hit, 0);
        tick();
        check("E_flag", if2._modify_flag, 0);
        check("E_data", if2._modify_data, 32'hFFFFFFFF);
        tick();
        check("E_cnt", cnt2, 1);

        // DEPTH=1 hold keeps the entry; one write after release
        if1.modify_flag = 1; if1.modify_address = 5'd7; if1.modify_data = 32'h11;
        tick();
        if1.modify_flag = 0; if1.modify_address = '0; if1.modify_data = '0; st1 = HOLD;
        #1;
        check("B_h0_flag", if1._modify_flag, 0);
        check("B_h0_hit", if1.fwd_hit, 1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("B_h%0d_flag", i), if1._modify_flag, 0);
            check($sformatf("B_h%0d_addr", i), if1._modify_address, 7);
            check($sformatf("B_h%0d_data", i), if1._modify_data, 32'h11);
        end
        st1 = '0;
        #1;
        check("B_rel_flag", if1._modify_flag, 1);
        check("B_rel_cnt", cnt1, 0);
        tick();
        check("B_after_flag", if1._modify_flag, 0);
        check("B_after_cnt", cnt1, 1);

        // DEPTH=3 flush + hold with three in flight
        for (int i = 1; i <= 3; i++) begin
            if3.modify_flag = 1; if3.modify_address = 5'(i); if3.modify_data = 32'(i * 32'h101);
            tick();
        end
        if3.modify_flag = 0; if3.modify_address = '0; if3.modify_data = '0;
        fl3 = 1; st3 = HOLD; if3.fwd_address = 5'd2;
        #1;
        check("C_flush_flag", if3._modify_flag, 0);
        check("C_pre_hit", if3.fwd_hit, 1);
        check("C_pre_fdata", if3.fwd_data, 32'h202);
        tick();
        fl3 = 0; st3 = '0; if3.fwd_address = 5'd1;
        #1;
        check("C_post_hit1", if3.fwd_hit, 0);
        check("C_post_flag", if3._modify_flag, 0);
        tick();
        check("C_t1_flag", if3._modify_flag, 0);
        tick();
        check("C_t2_flag", if3._modify_flag, 0);
        check("C_cnt", cnt3, 0);

        // DEPTH=3 youngest-match forwarding, in-order drain
        if3.modify_flag = 1; if3.modify_address = 5'd9; if3.modify_data = 32'hA;
        tick();
        if3.modify_data = 32'hB;
        tick();
        if3.modify_flag = 0; if3.modify_address = '0; if3.modify_data = '0; if3.fwd_address = 5'd9;
        #1;
        check("D_hit", if3.fwd_hit, 1);
        check("D_fdata", if3.fwd_data, 32'hB);
        if3.fwd_address = 5'd0;
        #1;
        check("D_x0_hit", if3.fwd_hit, 0);
        check("D_x0_fdata", if3.fwd_data, 0);
        tick();
        check("D_w1_flag", if3._modify_flag, 1);
        check("D_w1_data", if3._modify_data, 32'hA);
        tick();
        check("D_w2_flag", if3._modify_flag, 1);
        check("D_w2_data", if3._modify_data, 32'hB);
        check("D_w2_cnt", cnt3, 1);
        tick();
        check("D_end_flag", if3._modify_flag, 0);
        check("D_end_cnt", cnt3, 2);

        // Async reset mid-hold
        for (int i = 4; i <= 6; i++) begin
            if3.modify_flag = 1; if3.modify_address = 5'(i); if3.modify_data = 32'(i * 32'h11);
            tick();
        end
        if3.modify_flag = 0; if3.modify_address = '0; if3.modify_data = '0;
        st3 = HOLD; if3.fwd_address = 5'd5;
        #1;
        check("F_pre_addr", if3._modify_address, 4);
        check("F_pre_data", if3._modify_data, 32'h44);
        check("F_pre_hit", if3.fwd_hit, 1);
        #1;
        rst3 = 1;
        #1;
        check("F_rst_addr", if3._modify_address, 0);
        check("F_rst_data", if3._modify_data, 0);
        check("F_rst_hit", if3.fwd_hit, 0);
        check("F_rst_cnt", cnt3, 0);
        tick();
        rst3 = 0; st3 = '0;
        tick();
        check("F_rel_flag", if3._modify_flag, 0);
        check("F_rel_hit", if3.fwd_hit, 0);

        // CNT_W=4 wrap after 17 writes
        rst1 = 1;
        #1;
        rst1 = 0;
        check("W_rst_cnt", cnt1, 0);
        for (int i = 0; i < 17; i++) begin
            if1.modify_flag = 1; if1.modify_address = 5'(i + 1); if1.modify_data = 32'(i);
            tick();
        end
        if1.modify_flag = 0; if1.modify_address = '0; if1.modify_data = '0;
        #1;
        check("W_last_flag", if1._modify_flag, 1);
        check("W_pre_cnt", cnt1, 0);
        tick();
        check("W_cnt", cnt1, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
- Parametrised successor to the single-register MEM→WB latch. Carries register-file write requests from MEM to the register file through DEPTH pipeline stages.
- Stall holds contents instead of zeroing them; flush drops all in-flight writes.
- Adds in-flight forwarding lookup for the decode/execute hazard logic and a retired-write counter.

Parameters:
- DATA_W, 32, width of write data
- ADDR_W, 5, width of register address
- DEPTH, 1, number of pipeline stages (legal 1..4)
- STALL_W, 6, width of stall_state bus
- STALL_BIT, 4, index of stall_state bit that freezes this block
- CNT_W, 32, width of retire counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall_state  in  STALL_W  stall bus; bit STALL_BIT=1 freezes all stages
- flush  in  1  kill all in-flight writes
- modify_flag  in  1  MEM write request valid
- modify_address  in  ADDR_W  MEM destination register
- modify_data  in  DATA_W  MEM write data
- _modify_flag  out  1  register-file write enable
- _modify_address  out  ADDR_W  register-file write address
- _modify_data  out  DATA_W  register-file write data
- fwd_address  in  ADDR_W  hazard-lookup register address
- fwd_hit  out  1  an in-flight valid write targets fwd_address
- fwd_data  out  DATA_W  data of youngest matching in-flight write
- retire_count  out  CNT_W  number of writes delivered to register file

Behaviour:
- Clock and reset: single clock clk. Reset rst is asynchronous, active-high.
- Reset state: every stage flag/address/data = 0, retire_count = 0. Consequently _modify_flag=0, _modify_address=0, _modify_data=0, fwd_hit=0, fwd_data=0.
- Definitions: hold = stall_state[STALL_BIT]. Stage 0 is youngest; stage DEPTH-1 is oldest.
- Per-edge priority:
  - rst (async) first.
  - flush: all stage flags ← 0. Address/data ← 0.
  - hold: all stages keep their values.
  - advance: stage0 ← inputs; stage k ← stage k-1.
- Input qualification: a request with modify_address = 0 is loaded with flag forced to 0 (x0 is never written). Address/data are still captured.
- Outputs:
  - _modify_address = oldest stage address; _modify_data = oldest stage data.
  - _modify_flag = oldest flag AND NOT hold AND NOT flush (combinational gate).
  - Effect: each entry asserts the write enable in exactly one cycle, even across multi-cycle holds.
  - Latency: DEPTH cycles from capture to write enable, plus held cycles.
- Retire counter:
  - retire_count increments by 1 on each edge where _modify_flag = 1.
  - Wraps modulo 2^CNT_W.
  - Flush does not reset it; only rst does.
- Forwarding (combinational):
  - Search stages 0..DEPTH-1 for flag=1 and address=fwd_address, youngest first.
  - fwd_hit = 1 if any match; fwd_data = data of youngest match, else 0.
  - fwd_address = 0 always gives fwd_hit = 0.
  - Lookup ignores hold and flush; it reflects current register contents.
- Boundary cases:
  - hold and flush together: flush wins and all stages clear.
  - Reset asserted mid-hold: clears immediately, asynchronously. On release, the pipe is empty.
  - DEPTH=1: behaves as a single register with hold semantics. Must differ from the old latch: hold keeps the entry, it does not zero it.
  - Same address in multiple stages: forwarding returns the youngest. The register file receives the writes in order, oldest first.
- Illegal configuration: DEPTH outside 1..4 is a configuration error, flagged by an elaboration-time check.

Decomposition:
- Shared defines (defines.v):
  - Data_size / Data_Address_size widths feed DATA_W / ADDR_W defaults.
  - Stall_size feeds STALL_W.
  - New constant `Stall_WB = 4 for STALL_BIT.
- One sub-module, wb_stage_reg: a single flag/address/data register with async reset, flush-clear, hold and load. mem_wb_pipe instantiates DEPTH of them via generate.
- Forwarding priority mux and retire counter stay in the top module.

Test Plan:
- DEPTH=2: after reset, write x5=0xDEADBEEF at cycle 0 → _modify_flag=1, address 5, data 0xDEADBEEF at cycle 2 only; retire_count=1.
- DEPTH=1: hold for 3 cycles with x7=0x11 captured → _modify_flag=0 during hold, then exactly one write of x7=0x11 once hold drops; retire_count=1, not 4.
- DEPTH=3: flush with x1, x2, x3 in flight plus hold asserted → no write enable ever asserts for them; fwd_hit=0 next cycle; retire_count unchanged.
- DEPTH=3: x9=0xA in stage 1 and x9=0xB in stage 0, fwd_address=9 → fwd_hit=1, fwd_data=0xB. fwd_address=0 → fwd_hit=0.
- Request to x0 with data 0xFFFFFFFF → no write enable, no forward hit, retire_count unchanged.
- Assert rst asynchronously between edges while hold=1 with valid entries → all outputs 0 immediately. Then CNT_W=4 with 17 writes → retire_count=1 (wrap).
